// File: rtl/spi_pkg.sv
// Shared SPI definitions: transmitter FSM states and mode-0 constants
// used by both the master transmitter and the receive path.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOW,
    S_HIGH,
    S_STALL,
    S_HOLD,
    S_GAP
  } spi_tx_state_t;

  localparam int   SPI_BITS_PER_BYTE = 8;
  localparam logic SPI_CPOL          = 1'b0;
  localparam logic SPI_CPHA          = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for SCK generation: tick marks the last clk cycle of
// each HALF_DIV-cycle half-period; restart realigns the count to zero.
module spi_clk_div #(
  parameter int HALF_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_tx_master.sv
// SPI mode-0 master transmitter with a one-byte holding register so SCK can
// run continuously across bytes. Define SPI_TX_MASTER_MISO_EN for MISO capture.
module spi_tx_master
  import spi_pkg::*;
#(
  parameter int HALF_DIV   = 50,
  parameter int GAP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sck,
  output logic       mosi,
  output logic       ssel_n,
  output logic       busy
`ifdef SPI_TX_MASTER_MISO_EN
  ,
  input  logic       miso,
  output logic [7:0] rx_data,
  output logic       rx_valid
`endif
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    BIT_LAST = 3'(SPI_BITS_PER_BYTE - 1);

  spi_tx_state_t state_q, state_d;

  logic [7:0]    hold_data_q, hold_data_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_full_q, hold_full_d;
  logic [7:0]    shift_q, shift_d;
  logic          shift_last_q, shift_last_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          ssel_n_q, ssel_n_d;
  logic          busy_q, busy_d;
  logic          restart, tick, load;

  spi_clk_div #(.HALF_DIV(HALF_DIV)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    bit_cnt_d    = bit_cnt_q;
    gap_d        = gap_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    ssel_n_d     = ssel_n_q;
    restart      = 1'b0;
    load         = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_data_d = tx_data;
      hold_last_d = tx_last;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: if (hold_full_q) begin
        load     = 1'b1;
        ssel_n_d = 1'b0;
        restart  = 1'b1;
        state_d  = S_START;
      end
      S_START: if (tick) begin
        sck_d   = 1'b1;
        state_d = S_HIGH;
      end
      S_HIGH: if (tick) begin
        sck_d = 1'b0;
        if (bit_cnt_q != BIT_LAST) begin
          shift_d   = {shift_q[6:0], 1'b0};
          mosi_d    = shift_q[6];
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = S_LOW;
        end else if (shift_last_q) begin
          state_d = S_HOLD;
        end else if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_LOW;
        end else begin
          state_d = S_STALL;
        end
      end
      S_LOW: if (tick) begin
        sck_d   = 1'b1;
        state_d = S_HIGH;
      end
      // Restart so the first LOW after an underrun is a full half-period.
      S_STALL: if (hold_full_q) begin
        load    = 1'b1;
        restart = 1'b1;
        state_d = S_LOW;
      end
      S_HOLD: if (tick) begin
        ssel_n_d = 1'b1;
        mosi_d   = 1'b0;
        gap_d    = '0;
        state_d  = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      shift_d      = hold_data_q;
      shift_last_d = hold_last_q;
      mosi_d       = hold_data_q[7];
      bit_cnt_d    = '0;
      hold_full_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      bit_cnt_q    <= '0;
      gap_q        <= '0;
      sck_q        <= SPI_CPOL;
      mosi_q       <= 1'b0;
      ssel_n_q     <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_q        <= gap_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      ssel_n_q     <= ssel_n_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_ready = ~hold_full_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign ssel_n   = ssel_n_q;
  assign busy     = busy_q;

`ifdef SPI_TX_MASTER_MISO_EN
  logic [1:0] miso_sync_q;
  logic [7:0] rx_shift_q, rx_data_q;
  logic       rx_valid_q;
  logic       sck_rise, byte_done;

  assign sck_rise  = sck_d & ~sck_q;
  assign byte_done = (state_q == S_HIGH) && tick && (bit_cnt_q == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sync_q <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      miso_sync_q <= {miso_sync_q[0], miso};
      rx_valid_q  <= byte_done;
      if (sck_rise)  rx_shift_q <= {rx_shift_q[6:0], miso_sync_q[1]};
      if (byte_done) rx_data_q  <= rx_shift_q;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  // Transmit-only build: no receive path.
`endif

endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master: a model slave decodes MOSI on rising SCK
// and records edge timing; each step checks against hand-computed values.
module tb_spi_tx_master;

  localparam int HD  = 50;
  localparam int GAP = 100;
  localparam logic [7:0] MISO_PAT = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_last, tx_valid;
  logic       tx_ready, sck, mosi, ssel_n, busy;

  int vectors = 0;
  int miscompares = 0;

`ifdef SPI_TX_MASTER_MISO_EN
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  int         rx_pulses = 0;
`endif

  spi_tx_master #(.HALF_DIV(HD), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .sck      (sck),
    .mosi     (mosi),
    .ssel_n   (ssel_n),
    .busy     (busy)
`ifdef SPI_TX_MASTER_MISO_EN
    ,
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
`endif
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Model slave and edge-timing monitor.
  logic [7:0] rx_q[$];
  logic [7:0] sh = 8'h00;
  int   nbits = 0, rises = 0, first_rise = 0, last_rise = 0, period_bad = 0;
  int   last_fall = 0, ssel_rise_cyc = 0, ssel_fall_cyc = 0, total_bytes = 0;
  int   fall_cnt = 0;
  logic psck = 1'b0, pssel = 1'b1;

  always @(sck or ssel_n) begin
    if (ssel_n === 1'b0 && pssel === 1'b1) begin
      ssel_fall_cyc = cyc; rises = 0; period_bad = 0; fall_cnt = 0; nbits = 0;
    end
    if (ssel_n === 1'b1 && pssel !== 1'b1) begin
      ssel_rise_cyc = cyc; nbits = 0;
    end
    if (sck === 1'b1 && psck === 1'b0 && ssel_n === 1'b0) begin
      if (rises == 0) first_rise = cyc;
      else if (cyc - last_rise != 2*HD) period_bad++;
      last_rise = cyc;
      rises++;
      sh = {sh[6:0], mosi};
      nbits++;
      if (nbits == 8) begin
        rx_q.push_back(sh); nbits = 0; total_bytes++;
      end
    end
    if (sck === 1'b0 && psck === 1'b1) begin
      last_fall = cyc; fall_cnt++;
    end
    psck = sck; pssel = ssel_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef SPI_TX_MASTER_MISO_EN
  logic [2:0] midx;
  assign midx = 3'(7 - fall_cnt);
  assign miso = MISO_PAT[midx];
  always @(negedge clk) if (rx_valid === 1'b1) begin
    rx_pulses++;
    chk("rx_data", {24'h0, rx_data}, {24'h0, MISO_PAT});
  end
`endif

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk("accept_timeout", 32'(n), 0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_ssel(input logic lvl, input string tag);
    int n = 0;
    while (ssel_n !== lvl && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk(tag, {31'h0, ssel_n}, {31'h0, lvl});
  endtask

  initial begin
    int base, t0, r, n;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ssel_n",   {31'h0, ssel_n},   1);
    chk("rst_sck",      {31'h0, sck},      0);
    chk("rst_mosi",     {31'h0, mosi},     0);
    chk("rst_tx_ready", {31'h0, tx_ready}, 1);
    chk("rst_busy",     {31'h0, busy},     0);
    @(negedge clk); rst_n = 1'b1;

    // Frame 1: AA 55 00(last), streamed with no stall.
    base = rx_q.size();
    @(negedge clk);
    tx_data = 8'hAA; tx_last = 1'b0; tx_valid = 1'b1;
    @(posedge clk); #1;
    chk("lat_c1_ready", {31'h0, tx_ready}, 0);
    chk("lat_c1_ssel",  {31'h0, ssel_n},   1);
    @(posedge clk); #1;
    t0 = cyc;
    chk("lat_c2_ssel",  {31'h0, ssel_n},   0);
    chk("lat_c2_mosi",  {31'h0, mosi},     1);
    chk("lat_c2_busy",  {31'h0, busy},     1);
    chk("lat_c2_ready", {31'h0, tx_ready}, 1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h00, 1'b1);
    wait_ssel(1'b1, "f1_end_timeout");
    #1;
    chk("f1_first_rise", 32'(first_rise - t0), HD);
    chk("f1_nbytes",     32'(rx_q.size() - base), 3);
    chk("f1_b0", {24'h0, rx_q[base]},   32'hAA);
    chk("f1_b1", {24'h0, rx_q[base+1]}, 32'h55);
    chk("f1_b2", {24'h0, rx_q[base+2]}, 32'h00);
    chk("f1_rises",      32'(rises), 24);
    chk("f1_period_bad", 32'(period_bad), 0);
    chk("f1_fall_to_ssel", 32'(ssel_rise_cyc - last_fall), HD);
    chk("f1_mosi_idle",  {31'h0, mosi}, 0);
    chk("f1_busy_gap",   {31'h0, busy}, 1);

    // Frame 2 offered during the gap.
    r = ssel_rise_cyc;
    base = rx_q.size();
    send_byte(8'h00, 1'b0);
    chk("f2_gap_ssel", {31'h0, ssel_n}, 1);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b1);
    wait_ssel(1'b1, "f2_end_timeout");
    #1;
    chk("f2_gap_len", {31'h0, (ssel_fall_cyc - r) >= GAP + 1}, 1);
    chk("f2_nbytes",  32'(rx_q.size() - base), 3);
    chk("f2_b0", {24'h0, rx_q[base]},   32'h00);
    chk("f2_b1", {24'h0, rx_q[base+1]}, 32'h55);
    chk("f2_b2", {24'h0, rx_q[base+2]}, 32'hAA);

    // Underrun: 3C, then C3(last) 2000 cycles later.
    base = rx_q.size();
    send_byte(8'h3C, 1'b0);
    repeat (1500) @(posedge clk);
    #1;
    chk("stall_sck_a",  {31'h0, sck},    0);
    chk("stall_ssel_a", {31'h0, ssel_n}, 0);
    chk("stall_busy",   {31'h0, busy},   1);
    repeat (499) @(posedge clk);
    #1;
    chk("stall_sck_b",  {31'h0, sck},    0);
    chk("stall_ssel_b", {31'h0, ssel_n}, 0);
    send_byte(8'hC3, 1'b1);
    wait_ssel(1'b1, "f3_end_timeout");
    #1;
    chk("f3_nbytes", 32'(rx_q.size() - base), 2);
    chk("f3_b0", {24'h0, rx_q[base]},   32'h3C);
    chk("f3_b1", {24'h0, rx_q[base+1]}, 32'hC3);
    chk("f3_rises", 32'(rises), 16);

    // Reset after 3 SCK rises of a frame.
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk("idle_timeout", {31'h0, busy}, 0);
    base = rx_q.size();
    send_byte(8'hF0, 1'b1);
    wait_ssel(1'b0, "f4_start_timeout");
    n = 0;
    while (rises < 3 && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk("rise3_timeout", 32'(rises), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_ssel",  {31'h0, ssel_n},   1);
    chk("mrst_sck",   {31'h0, sck},      0);
    chk("mrst_mosi",  {31'h0, mosi},     0);
    chk("mrst_busy",  {31'h0, busy},     0);
    chk("mrst_ready", {31'h0, tx_ready}, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_nbytes", 32'(rx_q.size() - base), 0);
    send_byte(8'h81, 1'b1);
    wait_ssel(1'b0, "f5_start_timeout");
    wait_ssel(1'b1, "f5_end_timeout");
    #1;
    chk("f5_nbytes", 32'(rx_q.size() - base), 1);
    chk("f5_b0", {24'h0, rx_q[base]}, 32'h81);
    chk("f5_rises", 32'(rises), 8);

`ifdef SPI_TX_MASTER_MISO_EN
    repeat (4) @(posedge clk);
    #1;
    chk("rx_pulses", 32'(rx_pulses), 32'(total_bytes));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
